// File: rtl/opl3_sample_pkg.sv
// Shared constants for the OPL3 sample FIFO: register offsets, STATUS bits, CTRL fields.
package opl3_sample_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int unsigned STAT_EMPTY_BIT = 8;
    localparam int unsigned STAT_FULL_BIT  = 9;
    localparam int unsigned STAT_OVFL_BIT  = 10;
    localparam int unsigned STAT_UDFL_BIT  = 11;

    localparam int unsigned CTRL_FLUSH_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;
    localparam int unsigned CTRL_THR_LSB   = 16;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/sample_fifo_ram.sv
// Storage array for the sample FIFO: synchronous write, asynchronous read, no pointers.
module sample_fifo_ram #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/opl3_sample_fifo.sv
// Stereo PCM capture FIFO between the OPL3 sample strobe and the CPU register window.
module opl3_sample_fifo
    import opl3_sample_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned SAMPLE_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_clk,
    input  logic [SAMPLE_W-1:0] channel_a,
    input  logic [SAMPLE_W-1:0] channel_b,
    input  logic                sel,
    input  logic [1:0]          addr,
    input  logic [3:0]          wstrb,
    input  logic [BUS_W-1:0]    wdata,
    output logic                ready,
    output logic [BUS_W-1:0]    rdata,
    output logic                irq
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    bus_state_t state, state_next;

    logic                  sync1, sync2, sync3;
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [CNT_W-1:0]      count, threshold;
    logic                  ovfl, udfl;

    logic                  rise_c, empty_c, full_c, wr_c, fire_c;
    logic                  pop_c, udfl_set_c, flush_c, clear_c, thr_we_c;
    logic                  push_ok_c, ovfl_set_c, ram_we_c;
    logic [BUS_W-1:0]      head_c, push_word_c, status_c, rdata_next_c;
    logic                  unused_wdata;

    assign rise_c      = sync2 & ~sync3;
    assign empty_c     = (count == '0);
    assign full_c      = (count == CNT_W'(DEPTH));
    assign wr_c        = |wstrb;
    assign push_word_c = BUS_W'({channel_a, channel_b});
    // A push into a full FIFO only lands if a pop frees the slot on the same edge
    assign push_ok_c   = rise_c & (~full_c | pop_c);
    assign ovfl_set_c  = rise_c & full_c & ~pop_c & ~flush_c;
    assign ram_we_c    = push_ok_c & ~flush_c;
    assign ready       = (state == BUS_ACK);
    assign irq         = (threshold != '0) && (count >= threshold);
    assign unused_wdata = ^wdata;

    sample_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (BUS_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (wptr),
        .wdata (push_word_c),
        .raddr (rptr),
        .rdata (head_c)
    );

    // STATUS word assembly
    always_comb begin
        status_c                 = '0;
        status_c[CNT_W-1:0]      = count;
        status_c[STAT_EMPTY_BIT] = empty_c;
        status_c[STAT_FULL_BIT]  = full_c;
        status_c[STAT_OVFL_BIT]  = ovfl;
        status_c[STAT_UDFL_BIT]  = udfl;
    end

    // Bus FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BUS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus FSM next state: every access is IDLE -> ACK -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            BUS_IDLE: if (sel) state_next = BUS_ACK;
            BUS_ACK:  state_next = BUS_IDLE;
            default:  state_next = BUS_IDLE;
        endcase
    end

    // Bus FSM outputs: access decode and side-effect strobes for the acknowledging edge
    always_comb begin
        fire_c       = 1'b0;
        pop_c        = 1'b0;
        udfl_set_c   = 1'b0;
        flush_c      = 1'b0;
        clear_c      = 1'b0;
        thr_we_c     = 1'b0;
        rdata_next_c = '0;
        if (state == BUS_IDLE && sel) begin
            fire_c = 1'b1;
            case (addr)
                REG_DATA: begin
                    if (!wr_c) begin
                        if (empty_c) begin
                            udfl_set_c = 1'b1;
                        end else begin
                            pop_c        = 1'b1;
                            rdata_next_c = head_c;
                        end
                    end
                end
                REG_STATUS: begin
                    if (!wr_c) rdata_next_c = status_c;
                end
                REG_CTRL: begin
                    if (wr_c) begin
                        flush_c  = wdata[CTRL_FLUSH_BIT];
                        clear_c  = wdata[CTRL_CLEAR_BIT];
                        thr_we_c = 1'b1;
                    end else begin
                        rdata_next_c[CTRL_THR_LSB +: CNT_W] = threshold;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sample strobe synchronizer and edge register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sample_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Read data register, zero outside the acknowledge cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= rdata_next_c;
        end
    end

    // FIFO pointers, occupancy, sticky flags and threshold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ovfl      <= 1'b0;
            udfl      <= 1'b0;
            threshold <= '0;
        end else begin
            if (flush_c) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push_ok_c) wptr <= wptr + DEPTH_LOG2'(1);
                if (pop_c)     rptr <= rptr + DEPTH_LOG2'(1);
                case ({push_ok_c, pop_c})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: ;
                endcase
            end
            if (clear_c) begin
                ovfl <= 1'b0;
                udfl <= 1'b0;
            end
            if (ovfl_set_c) ovfl <= 1'b1;
            if (udfl_set_c) udfl <= 1'b1;
            if (thr_we_c)   threshold <= wdata[CTRL_THR_LSB +: CNT_W];
        end
    end

endmodule

// File: tb/tb_opl3_sample_fifo.sv
// Self-checking bench for opl3_sample_fifo: directed vectors plus randomized traffic vs a queue model.
module tb_opl3_sample_fifo;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_clk;
    logic [15:0] channel_a, channel_b;
    logic        sel;
    logic [1:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        irq;

    opl3_sample_fifo #(
        .DEPTH_LOG2 (4),
        .SAMPLE_W   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_clk (sample_clk),
        .channel_a  (channel_a),
        .channel_b  (channel_b),
        .sel        (sel),
        .addr       (addr),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .ready      (ready),
        .rdata      (rdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: plain queue plus sticky flags and threshold
    logic [31:0] mq[$];
    bit          m_ovfl = 0;
    bit          m_udfl = 0;
    int          m_thr  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic m_push(input logic [31:0] w);
        if (mq.size() == DEPTH) m_ovfl = 1;
        else mq.push_back(w);
    endtask

    task automatic m_pop(output logic [31:0] w);
        if (mq.size() == 0) begin
            m_udfl = 1;
            w = 32'h0;
        end else begin
            w = mq.pop_front();
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(mq.size());
        s[8]  = (mq.size() == 0);
        s[9]  = (mq.size() == DEPTH);
        s[10] = m_ovfl;
        s[11] = m_udfl;
        return s;
    endfunction

    function automatic logic m_irq();
        return (m_thr != 0) && (mq.size() >= m_thr);
    endfunction

    task automatic m_ctrl_write(input logic [31:0] w);
        m_thr = int'(w[20:16]);
        if (w[0]) mq.delete();
        if (w[1]) begin
            m_ovfl = 0;
            m_udfl = 0;
        end
    endtask

    // One bus access; starts and ends 1 time unit after a rising edge
    task automatic bus_access(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                              output logic [31:0] rd);
        bit got;
        got   = 0;
        sel   = 1'b1;
        addr  = a;
        wstrb = s;
        wdata = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ready) got = 1;
        end
        rd    = rdata;
        sel   = 1'b0;
        wstrb = 4'h0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL bus_timeout: ready=0 after 4 cycles, expected 1");
        end
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(ready), 32'h0);
    endtask

    task automatic pulse(input logic [15:0] a, input logic [15:0] b);
        channel_a  = a;
        channel_b  = b;
        sample_clk = 1'b1;
        repeat (3) @(posedge clk); #1;
        sample_clk = 1'b0;
        m_push({a, b});
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic read_data(input string name);
        logic [31:0] rd, exp;
        bus_access(2'd0, 4'h0, 32'h0, rd);
        m_pop(exp);
        check(name, rd, exp);
    endtask

    task automatic read_status(input string name, input logic [31:0] exp);
        logic [31:0] rd;
        bus_access(2'd1, 4'h0, 32'h0, rd);
        check(name, rd, exp);
    endtask

    task automatic read_ctrl(input string name);
        logic [31:0] rd;
        bus_access(2'd2, 4'h0, 32'h0, rd);
        check(name, rd, 32'(m_thr) << 16);
    endtask

    task automatic write_ctrl(input logic [31:0] w);
        logic [31:0] rd;
        bus_access(2'd2, 4'hF, w, rd);
        m_ctrl_write(w);
        check("ctrl_wr_rdata", rd, 32'h0);
    endtask

    task automatic check_irq(input string name);
        check(name, 32'(irq), 32'(m_irq()));
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[3];

    initial begin
        logic [31:0] rd, exp;
        int op;
        int kind;
        logic [31:0] w;

        vecs[0] = '{16'h1111, 16'h2222, 32'h1111_2222};
        vecs[1] = '{16'h3333, 16'h4444, 32'h3333_4444};
        vecs[2] = '{16'h5555, 16'h6666, 32'h5555_6666};

        reset      = 1'b1;
        sample_clk = 1'b0;
        channel_a  = 16'h0;
        channel_b  = 16'h0;
        sel        = 1'b0;
        addr       = 2'd0;
        wstrb      = 4'h0;
        wdata      = 32'h0;
        repeat (3) @(posedge clk); #1;
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq",   32'(irq), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        read_status("rst_status", 32'h0000_0100);

        // Three captures, then drain in order
        for (int i = 0; i < 3; i++) pulse(vecs[i].a, vecs[i].b);
        read_status("three_count", 32'h0000_0003);
        for (int i = 0; i < 3; i++) begin
            bus_access(2'd0, 4'h0, 32'h0, rd);
            m_pop(exp);
            check($sformatf("vec_data%0d", i), rd, vecs[i].exp);
        end
        read_status("three_empty", 32'h0000_0100);

        // Overflow: 17 captures into a 16-deep FIFO
        for (int i = 0; i < 17; i++) pulse(16'(i), 16'(16'hA000 + i));
        read_status("full_ovfl", 32'h0000_0610);
        for (int i = 0; i < 16; i++) begin
            bus_access(2'd0, 4'h0, 32'h0, rd);
            m_pop(exp);
            check($sformatf("ovfl_data%0d", i), rd, {16'(i), 16'(16'hA000 + i)});
        end
        read_status("drained_ovfl", 32'h0000_0500);

        // Underflow, then flag clear
        bus_access(2'd0, 4'h0, 32'h0, rd);
        m_pop(exp);
        check("udfl_rdata", rd, 32'h0);
        read_status("udfl_status", 32'h0000_0D00);
        write_ctrl(32'h0000_0002);
        read_status("flags_cleared", 32'h0000_0100);

        // Threshold interrupt
        write_ctrl(32'h0004_0000);
        read_ctrl("ctrl_thr4");
        for (int i = 0; i < 3; i++) pulse(16'(16'h0100 + i), 16'(16'h0200 + i));
        check("irq_at3", 32'(irq), 32'h0);
        pulse(16'h0103, 16'h0203);
        check("irq_at4", 32'(irq), 32'h1);
        read_data("thr_pop");
        check("irq_after_pop", 32'(irq), 32'h0);

        // Fill to full, then capture on the same edge as a DATA pop
        for (int i = 0; i < 13; i++) pulse(16'($urandom), 16'($urandom));
        read_status("pre_coincide", 32'h0000_0210);
        channel_a  = 16'hC0DE;
        channel_b  = 16'hBEEF;
        sample_clk = 1'b1;
        repeat (2) @(posedge clk); #1;
        sel   = 1'b1;
        addr  = 2'd0;
        wstrb = 4'h0;
        @(posedge clk); #1;
        check("coin_ready", 32'(ready), 32'h1);
        m_pop(exp);
        m_push(32'hC0DE_BEEF);
        check("coin_rdata", rdata, exp);
        sel = 1'b0;
        @(posedge clk); #1;
        sample_clk = 1'b0;
        repeat (3) @(posedge clk); #1;
        read_status("post_coincide", 32'h0000_0210);
        for (int i = 0; i < 16; i++) read_data($sformatf("coin_drain%0d", i));
        read_status("coin_empty", m_status());

        // Reset in the middle of an acknowledged access with 5 entries and udfl set
        write_ctrl(32'h0004_0001);
        read_data("pre_rst_udfl");
        for (int i = 0; i < 5; i++) pulse(16'($urandom), 16'($urandom));
        check("pre_rst_irq", 32'(irq), 32'h1);
        sel   = 1'b1;
        addr  = 2'd0;
        wstrb = 4'h0;
        @(posedge clk); #1;
        check("pre_rst_ready", 32'(ready), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_ready", 32'(ready), 32'h0);
        check("rst_mid_irq",   32'(irq), 32'h0);
        sel = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        mq.delete();
        m_ovfl = 0;
        m_udfl = 0;
        m_thr  = 0;
        @(posedge clk); #1;
        read_status("post_rst_status", 32'h0000_0100);
        read_ctrl("post_rst_ctrl");

        // Randomized traffic against the queue model
        for (int n = 0; n < 250; n++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2, 3: pulse(16'($urandom), 16'($urandom));
                4, 5:       read_data("rnd_data");
                6:          read_status("rnd_status", m_status());
                7: begin
                    w = $urandom;
                    w[20:16] = 5'($urandom_range(0, 17));
                    w[0] = ($urandom_range(0, 3) == 0);
                    write_ctrl(w);
                end
                8: read_ctrl("rnd_ctrl");
                default: begin
                    kind = int'($urandom_range(0, 2));
                    if (kind == 0)      bus_access(2'd3, 4'h0, 32'h0, rd);
                    else if (kind == 1) bus_access(2'd3, 4'hF, $urandom, rd);
                    else                bus_access(2'($urandom_range(0, 1)), 4'h3, $urandom, rd);
                    check("rnd_ignored", rd, 32'h0);
                end
            endcase
            check_irq("rnd_irq");
        end
        read_status("final_status", m_status());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
